afu_ctrl_regs: RTL and testbench

Parametrised AXI4-Lite control slave for the XRT AFU shell. It decodes host register accesses into the ap_ctrl start/done/idle/ready protocol and exposes NUM_ARGS 64-bit kernel argument registers. It also handles interrupt enable and status, and reports read-only device capabilities. It sits between the shell's s_axi_ctrl port and the Vortex wrapper, and replaces fixed-width per-design control decoding.

---
 rtl/afu_ctrl_regs_if.sv | 34 +++
 rtl/afu_ctrl_regs.sv | 199 +++++++++++++++++++
 tb/tb_afu_ctrl_regs.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/afu_ctrl_regs_if.sv
// AXI4-Lite control-port bundle between the shell (master) and afu_ctrl_regs (slave).
// A beat transfers on every rising edge where both valid and ready are high; valid
// never waits on ready, and payload is held stable while valid is high and ready is low.
interface afu_ctrl_regs_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/afu_ctrl_regs.sv
// AXI4-Lite control slave: ap_ctrl start/done/idle/ready handshake, interrupt
// enable/status, read-only capability word and NUM_ARGS 64-bit kernel arguments.
module afu_ctrl_regs #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ARGS   = 4
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  afu_ctrl_regs_if.slave          s_axi_ctrl,
  input  logic [63:0]             dev_caps,
  output logic                    ap_start,
  input  logic                    ap_ready,
  input  logic                    ap_done,
  input  logic                    ap_idle,
  output logic [64*NUM_ARGS-1:0]  args,
  output logic                    interrupt,
  output logic [1:0]              dbg_wr_state_o,
  output logic                    dbg_rd_state_o
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("afu_ctrl_regs: DATA_WIDTH must be 32");
  end
  if (NUM_ARGS < 1 || NUM_ARGS > 16) begin : g_bad_num_args
    $error("afu_ctrl_regs: NUM_ARGS must be in 1..16");
  end
  if (32 + 8 * NUM_ARGS > (1 << ADDR_WIDTH)) begin : g_bad_addr_width
    $error("afu_ctrl_regs: ADDR_WIDTH too small for NUM_ARGS");
  end

  typedef enum logic [1:0] {W_ADDR = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;
  typedef enum logic       {R_ADDR = 1'b0, R_DATA = 1'b1} rd_state_e;

  wr_state_e              wr_state_q, wr_state_d;
  rd_state_e              rd_state_q, rd_state_d;
  logic [IDX_W-1:0]       aw_idx_q, aw_idx_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   start_q, start_d;
  logic                   auto_restart_q, auto_restart_d;
  logic                   gie_q, gie_d;
  logic [1:0]             ier_q, ier_d;
  logic [1:0]             isr_q, isr_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic [64*NUM_ARGS-1:0] args_q, args_d;

  logic                   aw_fire, w_fire, ar_fire;
  logic [IDX_W-1:0]       rd_idx;
  logic [31:0]            rd_word;
  logic                   ctrl_wr;
  logic                   unused_addr_lsbs;

  assign aw_fire = (wr_state_q == W_ADDR) && s_axi_ctrl.awvalid;
  assign w_fire  = (wr_state_q == W_DATA) && s_axi_ctrl.wvalid;
  assign ar_fire = (rd_state_q == R_ADDR) && s_axi_ctrl.arvalid;
  assign rd_idx  = s_axi_ctrl.araddr[ADDR_WIDTH-1:2];
  assign ctrl_wr = w_fire && s_axi_ctrl.wstrb[0];
  assign unused_addr_lsbs = ^{s_axi_ctrl.awaddr[1:0], s_axi_ctrl.araddr[1:0]};

  // Write FSM: state register / next state / outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) wr_state_q <= W_ADDR;
    else           wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_ADDR:  if (s_axi_ctrl.awvalid) wr_state_d = W_DATA;
      W_DATA:  if (s_axi_ctrl.wvalid)  wr_state_d = W_RESP;
      W_RESP:  if (s_axi_ctrl.bready)  wr_state_d = W_ADDR;
      default: wr_state_d = W_ADDR;
    endcase
  end

  always_comb begin
    s_axi_ctrl.awready = (wr_state_q == W_ADDR);
    s_axi_ctrl.wready  = (wr_state_q == W_DATA);
    s_axi_ctrl.bvalid  = (wr_state_q == W_RESP);
    s_axi_ctrl.bresp   = 2'b00;
  end

  // Read FSM: state register / next state / outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rd_state_q <= R_ADDR;
    else           rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_ADDR:  if (s_axi_ctrl.arvalid) rd_state_d = R_DATA;
      R_DATA:  if (s_axi_ctrl.rready)  rd_state_d = R_ADDR;
      default: rd_state_d = R_ADDR;
    endcase
  end

  always_comb begin
    s_axi_ctrl.arready = (rd_state_q == R_ADDR);
    s_axi_ctrl.rvalid  = (rd_state_q == R_DATA);
    s_axi_ctrl.rdata   = rdata_q;
    s_axi_ctrl.rresp   = 2'b00;
  end

  // Read mux sees only registered state, so a same-cycle write is not visible yet.
  always_comb begin
    rd_word = '0;
    case (rd_idx)
      IDX_W'(0): rd_word = {24'd0, auto_restart_q, 3'd0, ready_q, ap_idle, done_q, start_q};
      IDX_W'(1): rd_word = {31'd0, gie_q};
      IDX_W'(2): rd_word = {30'd0, ier_q};
      IDX_W'(3): rd_word = {30'd0, isr_q};
      IDX_W'(4): rd_word = dev_caps[31:0];
      IDX_W'(5): rd_word = dev_caps[63:32];
      default:   rd_word = '0;
    endcase
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (rd_idx == IDX_W'(8 + 2 * i)) rd_word = args_q[64*i +: 32];
      if (rd_idx == IDX_W'(9 + 2 * i)) rd_word = args_q[64*i + 32 +: 32];
    end
  end

  // Register next state; hardware sets are applied last so they win over clears.
  always_comb begin
    aw_idx_d       = aw_fire ? s_axi_ctrl.awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
    rdata_d        = ar_fire ? rd_word : rdata_q;
    start_d        = start_q;
    auto_restart_d = auto_restart_q;
    gie_d          = gie_q;
    ier_d          = ier_q;
    isr_d          = isr_q;
    done_d         = done_q;
    ready_d        = ready_q;
    args_d         = args_q;

    if (ap_ready && !auto_restart_q) start_d = 1'b0;
    if (ctrl_wr && aw_idx_q == IDX_W'(0)) begin
      if (s_axi_ctrl.wdata[0]) start_d = 1'b1;
      auto_restart_d = s_axi_ctrl.wdata[7];
    end
    if (ctrl_wr && aw_idx_q == IDX_W'(1)) gie_d = s_axi_ctrl.wdata[0];
    if (ctrl_wr && aw_idx_q == IDX_W'(2)) ier_d = s_axi_ctrl.wdata[1:0];
    if (ctrl_wr && aw_idx_q == IDX_W'(3)) isr_d = isr_q & ~s_axi_ctrl.wdata[1:0];
    if (ap_done && ier_q[0])  isr_d[0] = 1'b1;
    if (ap_ready && ier_q[1]) isr_d[1] = 1'b1;

    if (ar_fire && rd_idx == IDX_W'(0)) begin
      done_d  = 1'b0;
      ready_d = 1'b0;
    end
    if (ap_done)  done_d  = 1'b1;
    if (ap_ready) ready_d = 1'b1;

    for (int i = 0; i < NUM_ARGS; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (w_fire && s_axi_ctrl.wstrb[b] && aw_idx_q == IDX_W'(8 + 2 * i))
          args_d[64*i + 8*b +: 8] = s_axi_ctrl.wdata[8*b +: 8];
        if (w_fire && s_axi_ctrl.wstrb[b] && aw_idx_q == IDX_W'(9 + 2 * i))
          args_d[64*i + 32 + 8*b +: 8] = s_axi_ctrl.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      aw_idx_q       <= '0;
      rdata_q        <= '0;
      start_q        <= 1'b0;
      auto_restart_q <= 1'b0;
      gie_q          <= 1'b0;
      ier_q          <= '0;
      isr_q          <= '0;
      done_q         <= 1'b0;
      ready_q        <= 1'b0;
      args_q         <= '0;
    end else begin
      aw_idx_q       <= aw_idx_d;
      rdata_q        <= rdata_d;
      start_q        <= start_d;
      auto_restart_q <= auto_restart_d;
      gie_q          <= gie_d;
      ier_q          <= ier_d;
      isr_q          <= isr_d;
      done_q         <= done_d;
      ready_q        <= ready_d;
      args_q         <= args_d;
    end
  end

  assign ap_start       = start_q;
  assign args           = args_q;
  assign interrupt      = gie_q & (|isr_q);
  assign dbg_wr_state_o = wr_state_q;
  assign dbg_rd_state_o = rd_state_q;

endmodule

// File: tb/tb_afu_ctrl_regs.sv
// Directed bench for afu_ctrl_regs: a register-map vector table plus hand-written
// sequences for start/auto-restart, interrupts, coincident set/clear and mid-transaction reset.
module tb_afu_ctrl_regs;
  localparam int AW = 8;
  localparam int NA = 4;
  localparam logic [63:0] CAPS = 64'hCAFEF00D_12345678;

  logic              ap_clk;
  logic              ap_rst_n;
  logic [63:0]       dev_caps;
  logic              ap_start;
  logic              ap_ready;
  logic              ap_done;
  logic              ap_idle;
  logic [64*NA-1:0]  args;
  logic              interrupt;
  logic [1:0]        dbg_wr_state;
  logic              dbg_rd_state;

  afu_ctrl_regs_if #(.ADDR_WIDTH(AW)) axi ();

  afu_ctrl_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_ARGS(NA)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .s_axi_ctrl     (axi),
    .dev_caps       (dev_caps),
    .ap_start       (ap_start),
    .ap_ready       (ap_ready),
    .ap_done        (ap_done),
    .ap_idle        (ap_idle),
    .args           (args),
    .interrupt      (interrupt),
    .dbg_wr_state_o (dbg_wr_state),
    .dbg_rd_state_o (dbg_rd_state)
  );

  // clock / reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit done_on_w, input bit hold_b);
    int n;
    axi.awvalid = 1'b1;
    axi.awaddr  = addr;
    n = 0;
    while (!axi.awready && n < 20) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check("wr_awready_wait", axi.awready, 1);
    @(posedge ap_clk); #1;
    axi.awvalid = 1'b0;
    check("wr_wready_after_aw", axi.wready, 1);
    axi.wvalid = 1'b1;
    axi.wdata  = data;
    axi.wstrb  = strb;
    if (done_on_w) ap_done = 1'b1;
    @(posedge ap_clk); #1;
    axi.wvalid = 1'b0;
    ap_done    = 1'b0;
    check("wr_bvalid_after_w", axi.bvalid, 1);
    check("wr_bresp", axi.bresp, 0);
    if (!hold_b) begin
      axi.bready = 1'b1;
      @(posedge ap_clk); #1;
      axi.bready = 1'b0;
      check("wr_awready_after_b", axi.awready, 1);
    end
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp, input string name,
                          input bit done_on_ar);
    int          n;
    logic [31:0] e;
    exp_q.push_back(exp);
    axi.arvalid = 1'b1;
    axi.araddr  = addr;
    n = 0;
    while (!axi.arready && n < 20) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check({name, "_arready_wait"}, axi.arready, 1);
    if (done_on_ar) ap_done = 1'b1;
    @(posedge ap_clk); #1;
    axi.arvalid = 1'b0;
    ap_done     = 1'b0;
    e = exp_q.pop_front();
    check({name, "_rvalid"}, axi.rvalid, 1);
    check(name, axi.rdata, e);
    @(posedge ap_clk); #1;
    check({name, "_held"}, axi.rdata, e);
    check({name, "_rresp"}, axi.rresp, 0);
    axi.rready = 1'b1;
    @(posedge ap_clk); #1;
    axi.rready = 1'b0;
    check({name, "_arready_after_r"}, axi.arready, 1);
  endtask

  task automatic pulse_ready();
    ap_ready = 1'b1;
    @(posedge ap_clk); #1;
    ap_ready = 1'b0;
  endtask

  task automatic pulse_done();
    ap_done = 1'b1;
    @(posedge ap_clk); #1;
    ap_done = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[23];

  initial begin
    axi.awvalid = 1'b0; axi.awaddr = '0;
    axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb = '0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0; axi.araddr = '0;
    axi.rready  = 1'b0;
    ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
    dev_caps = CAPS;
    ap_rst_n = 1'b0;

    vecs[0]  = '{1'b1, 8'h20, 32'hDEADBEEF, 4'b0011, 32'h0};
    vecs[1]  = '{1'b0, 8'h20, 32'h0,        4'h0,    32'h0000BEEF};
    vecs[2]  = '{1'b1, 8'h24, 32'h12345678, 4'hF,    32'h0};
    vecs[3]  = '{1'b0, 8'h24, 32'h0,        4'h0,    32'h12345678};
    vecs[4]  = '{1'b1, 8'h38, 32'hA5A5A5A5, 4'b1000, 32'h0};
    vecs[5]  = '{1'b0, 8'h38, 32'h0,        4'h0,    32'hA5000000};
    vecs[6]  = '{1'b0, 8'h3C, 32'h0,        4'h0,    32'h0};
    vecs[7]  = '{1'b1, 8'h10, 32'hFFFFFFFF, 4'hF,    32'h0};
    vecs[8]  = '{1'b0, 8'h10, 32'h0,        4'h0,    32'h12345678};
    vecs[9]  = '{1'b0, 8'h14, 32'h0,        4'h0,    32'hCAFEF00D};
    vecs[10] = '{1'b0, 8'h18, 32'h0,        4'h0,    32'h0};
    vecs[11] = '{1'b0, 8'h40, 32'h0,        4'h0,    32'h0};
    vecs[12] = '{1'b1, 8'h04, 32'h1,        4'hF,    32'h0};
    vecs[13] = '{1'b0, 8'h04, 32'h0,        4'h0,    32'h1};
    vecs[14] = '{1'b1, 8'h08, 32'h3,        4'hF,    32'h0};
    vecs[15] = '{1'b0, 8'h08, 32'h0,        4'h0,    32'h3};
    vecs[16] = '{1'b1, 8'h08, 32'h0,        4'b1110, 32'h0};
    vecs[17] = '{1'b0, 8'h08, 32'h0,        4'h0,    32'h3};
    vecs[18] = '{1'b1, 8'h04, 32'h0,        4'hF,    32'h0};
    vecs[19] = '{1'b1, 8'h08, 32'h0,        4'hF,    32'h0};
    vecs[20] = '{1'b0, 8'h04, 32'h0,        4'h0,    32'h0};
    vecs[21] = '{1'b0, 8'h0C, 32'h0,        4'h0,    32'h0};
    vecs[22] = '{1'b0, 8'h23, 32'h0,        4'h0,    32'h0000BEEF};

    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // reset state
    check("rst_awready", axi.awready, 1);
    check("rst_arready", axi.arready, 1);
    check("rst_bvalid", axi.bvalid, 0);
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_rdata", axi.rdata, 0);
    check("rst_ap_start", ap_start, 0);
    check("rst_interrupt", interrupt, 0);
    check("rst_args", args, 0);

    axi_read(8'h00, 32'h00000004, "rd_ctrl_idle", 1'b0);
    axi_read(8'h10, CAPS[31:0], "rd_caps_lo", 1'b0);

    // register map table
    for (int i = 0; i < 23; i++) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b0, 1'b0);
      else            axi_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);
    end
    check("args0", args[63:0], 64'h12345678_0000BEEF);
    check("args3", args[255:192], 64'h00000000_A5000000);
    check("args12", args[191:64], 128'h0);

    // single start, cleared by ap_ready
    axi_write(8'h00, 32'h1, 4'hF, 1'b0, 1'b0);
    check("start_set", ap_start, 1);
    pulse_ready();
    check("start_cleared", ap_start, 0);
    axi_read(8'h00, 32'h0000000C, "rd_ready_set", 1'b0);
    axi_read(8'h00, 32'h00000004, "rd_ready_cor", 1'b0);

    // auto_restart keeps start high; writing 0 does not clear start
    axi_write(8'h00, 32'h81, 4'hF, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      pulse_ready();
      check($sformatf("auto_restart_hold%0d", k), ap_start, 1);
    end
    axi_write(8'h00, 32'h0, 4'hF, 1'b0, 1'b0);
    check("start_write0_keeps", ap_start, 1);
    pulse_ready();
    check("start_cleared_after_ar_off", ap_start, 0);
    axi_read(8'h00, 32'h0000000C, "rd_ctrl_after_auto", 1'b0);

    // interrupt on done
    axi_write(8'h04, 32'h1, 4'hF, 1'b0, 1'b0);
    axi_write(8'h08, 32'h1, 4'hF, 1'b0, 1'b0);
    check("irq_idle", interrupt, 0);
    pulse_done();
    check("irq_raised", interrupt, 1);
    axi_read(8'h00, 32'h00000006, "rd_done_set", 1'b0);
    axi_read(8'h00, 32'h00000004, "rd_done_cor", 1'b0);
    axi_read(8'h0C, 32'h00000001, "rd_isr_done", 1'b0);
    axi_write(8'h0C, 32'h1, 4'hF, 1'b0, 1'b0);
    check("irq_w1c", interrupt, 0);

    // coincident set/clear: hardware set wins
    axi_read(8'h00, 32'h00000004, "rd_done_coincident", 1'b1);
    check("irq_coincident_read", interrupt, 1);
    axi_read(8'h00, 32'h00000006, "rd_done_after_coincident", 1'b0);
    axi_write(8'h0C, 32'h1, 4'hF, 1'b1, 1'b0);
    axi_read(8'h0C, 32'h00000001, "rd_isr_set_wins", 1'b0);
    check("irq_set_wins", interrupt, 1);
    axi_write(8'h0C, 32'h1, 4'hF, 1'b0, 1'b0);
    check("irq_cleared", interrupt, 0);
    axi_read(8'h0C, 32'h00000000, "rd_isr_cleared", 1'b0);

    // reset mid-transaction with a pending B beat
    axi_write(8'h28, 32'h11223344, 4'hF, 1'b0, 1'b1);
    check("pre_rst_bvalid", axi.bvalid, 1);
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", axi.bvalid, 0);
    check("mid_rst_args", args, 0);
    check("mid_rst_wready", axi.wready, 0);
    @(posedge ap_clk);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check("post_rst_awready", axi.awready, 1);
    check("post_rst_arready", axi.arready, 1);
    check("post_rst_bvalid", axi.bvalid, 0);
    axi_read(8'h04, 32'h0, "rd_gie_after_rst", 1'b0);
    axi_read(8'h20, 32'h0, "rd_arg0_after_rst", 1'b0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
